pipe_if: RTL

- Instruction-fetch stage of the 54-instruction static pipeline CPU.
- Producer end of the decode stage's input interface:
  - owns the fetch PC and drives the instruction-memory request handshake;
  - holds the IF/ID pipeline register (pc4, instruction, valid);
  - consumes decode's redirect outputs (pc_mux_sel, target PCs) and its stall.
- MIPS delay-slot semantics: the instruction after any redirecting instruction always issues.

---
 rtl/pipe_if_pkg.sv | 19 +
 rtl/pipe_if_if.sv | 31 +++
 rtl/pipe_if_pc_sel.sv | 26 ++
 rtl/pipe_if.sv | 125 ++++++++++++
 4 files changed

// File: rtl/pipe_if_pkg.sv
// Shared definitions for the instruction-fetch stage and the decode-side redirect logic.
package pipe_if_pkg;

  localparam logic [2:0] PC_SEQ = 3'd0;
  localparam logic [2:0] PC_J   = 3'd1;
  localparam logic [2:0] PC_R   = 3'd2;
  localparam logic [2:0] PC_B   = 3'd3;
  localparam logic [2:0] PC_CP0 = 3'd4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;

  typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_HOLD} fetch_state_e;

  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pipe_if_if.sv
// Fetch-stage bundle: instruction-memory handshake, IF/ID register and decode feedback.
interface pipe_if_if;
  import pipe_if_pkg::*;

  logic        stall;
  logic [2:0]  id_pc_mux_sel;
  logic [31:0] id_j_pc;
  logic [31:0] id_r_pc;
  logic [31:0] id_b_pc;
  logic [31:0] id_cp0_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc4;
  logic [31:0] if_instruction;

  modport master (
    input  stall, id_pc_mux_sel, id_j_pc, id_r_pc, id_b_pc, id_cp0_pc,
    input  imem_ready, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc4, if_instruction
  );

  modport slave (
    output stall, id_pc_mux_sel, id_j_pc, id_r_pc, id_b_pc, id_cp0_pc,
    output imem_ready, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc4, if_instruction
  );

endinterface

// File: rtl/pipe_if_pc_sel.sv
// Redirect target mux; selects among decode's target PCs and word-aligns the result.
module if_pc_sel
  import pipe_if_pkg::*;
(
  input  logic [2:0]  sel_i,
  input  logic [31:0] j_pc_i,
  input  logic [31:0] r_pc_i,
  input  logic [31:0] b_pc_i,
  input  logic [31:0] cp0_pc_i,
  output logic [31:0] target_o,
  output logic        redirect_o
);

  always_comb begin
    target_o   = '0;
    redirect_o = 1'b0;
    case (sel_i)
      PC_J:   begin target_o = pc_align(j_pc_i);   redirect_o = 1'b1; end
      PC_R:   begin target_o = pc_align(r_pc_i);   redirect_o = 1'b1; end
      PC_B:   begin target_o = pc_align(b_pc_i);   redirect_o = 1'b1; end
      PC_CP0: begin target_o = pc_align(cp0_pc_i); redirect_o = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_if.sv
// Instruction-fetch stage: owns fetch PC, imem request handshake and the IF/ID register.
// state    | meaning
// ST_BOOT  | one idle cycle after reset, no request
// ST_FETCH | request outstanding at fetch_pc
// ST_HOLD  | response parked in buffer until IF/ID frees up
module pipe_if
  import pipe_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input logic       clk,
  input logic       rst,
  pipe_if_if.master ifb
);

  fetch_state_e state_q;
  logic         req_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  redirect_pc_q;
  logic         redirect_pending_q;
  logic [31:0]  buf_pc4_q;
  logic [31:0]  buf_instr_q;
  logic         valid_q;
  logic [31:0]  pc4_q;
  logic [31:0]  instr_q;

  logic        id_accept;
  logic        slot_free;
  logic        completion;
  logic        redirect;
  logic        sel_redirect;
  logic [31:0] sel_target;
  logic [31:0] fetch_pc4;

  if_pc_sel u_pc_sel (
    .sel_i      (ifb.id_pc_mux_sel),
    .j_pc_i     (ifb.id_j_pc),
    .r_pc_i     (ifb.id_r_pc),
    .b_pc_i     (ifb.id_b_pc),
    .cp0_pc_i   (ifb.id_cp0_pc),
    .target_o   (sel_target),
    .redirect_o (sel_redirect)
  );

  assign id_accept  = valid_q & ~ifb.stall;
  assign slot_free  = ~valid_q | id_accept;
  assign completion = (state_q == ST_FETCH) & ifb.imem_ready;
  assign redirect   = id_accept & sel_redirect;
  assign fetch_pc4  = fetch_pc_q + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= ST_BOOT;
      req_q              <= 1'b0;
      fetch_pc_q         <= RESET_PC;
      redirect_pc_q      <= '0;
      redirect_pending_q <= 1'b0;
      buf_pc4_q          <= '0;
      buf_instr_q        <= NOP_WORD;
      valid_q            <= 1'b0;
      pc4_q              <= '0;
      instr_q            <= NOP_WORD;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q <= ST_FETCH;
          req_q   <= 1'b1;
        end
        ST_FETCH: begin
          if (ifb.imem_ready && slot_free) begin
            valid_q <= 1'b1;
            pc4_q   <= fetch_pc4;
            instr_q <= ifb.imem_rdata;
          end else if (ifb.imem_ready) begin
            buf_pc4_q   <= fetch_pc4;
            buf_instr_q <= ifb.imem_rdata;
            state_q     <= ST_HOLD;
            req_q       <= 1'b0;
          end else if (id_accept) begin
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
          end
        end
        ST_HOLD: begin
          // Not free here implies no accept, so no bubble case is needed.
          if (slot_free) begin
            valid_q <= 1'b1;
            pc4_q   <= buf_pc4_q;
            instr_q <= buf_instr_q;
            state_q <= ST_FETCH;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_BOOT;
          req_q   <= 1'b0;
        end
      endcase

      // A redirect whose delay slot has not been fetched yet waits for that completion.
      if (redirect) begin
        if ((fetch_pc_q == pc4_q) && !completion) begin
          redirect_pc_q      <= sel_target;
          redirect_pending_q <= 1'b1;
        end else begin
          fetch_pc_q <= sel_target;
        end
      end else if (completion) begin
        if (redirect_pending_q) begin
          fetch_pc_q         <= redirect_pc_q;
          redirect_pending_q <= 1'b0;
        end else begin
          fetch_pc_q <= fetch_pc4;
        end
      end
    end
  end

  assign ifb.imem_req       = req_q;
  assign ifb.imem_addr      = fetch_pc_q;
  assign ifb.if_valid       = valid_q;
  assign ifb.if_pc4         = pc4_q;
  assign ifb.if_instruction = instr_q;

endmodule
